neuron_datapath: RTL and testbench

Shared compute engine at the datapath end of the per-thread instruction router. It accepts one instruction per `start_dp` handshake, runs a saturating Q8.8 fixed-point operation against a persistent accumulator, and returns a 16-bit result with a one-cycle `finished_dp` pulse. It executes one instruction at a time; the router serialises thread requests onto it.

---
 rtl/neuron_dp_pkg.sv | 60 ++++++
 rtl/neuron_datapath_if.sv | 28 ++
 rtl/neuron_datapath_seq_mult.sv | 59 +++++
 rtl/neuron_datapath.sv | 110 +++++++++++
 tb/tb_neuron_datapath.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/neuron_dp_pkg.sv
`timescale 1ns/1ps
// Shared types, widths and saturating arithmetic helpers for the neuron datapath.
// Combinational helpers only; no timing or flow-control behaviour lives here.
package neuron_dp_pkg;

    localparam int INSTRUCTION_WIDTH = 36;
    localparam int RESULT_WIDTH      = 16;
    localparam int OPERAND_WIDTH     = 16;
    localparam int OPCODE_WIDTH      = 4;
    localparam int Q_SHIFT           = 8;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_MUL   = 4'd3,
        OP_MAC   = 4'd4,
        OP_CLR   = 4'd5,
        OP_RELU  = 4'd6,
        OP_RDACC = 4'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0]  opcode;
        logic [OPERAND_WIDTH-1:0] a;
        logic [OPERAND_WIDTH-1:0] b;
    } instr_t;

    function automatic logic [RESULT_WIDTH-1:0] sat16(input logic signed [31:0] x);
        if (x > 32'sd32767)
            return 16'h7FFF;
        else if (x < -32'sd32768)
            return 16'h8000;
        else
            return x[15:0];
    endfunction

    function automatic logic [RESULT_WIDTH-1:0] sat_add(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        s = {x[15], x} + {y[15], y};
        return sat16({{15{s[16]}}, s});
    endfunction

    function automatic logic [RESULT_WIDTH-1:0] sat_sub(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        s = {x[15], x} - {y[15], y};
        return sat16({{15{s[16]}}, s});
    endfunction

    function automatic logic is_mul_op(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_MUL) || (op == OP_MAC);
    endfunction

endpackage

// File: rtl/neuron_datapath_if.sv
`timescale 1ns/1ps
// Router-to-datapath request/completion bundle.
// master = instruction router, slave = neuron_datapath.
interface neuron_datapath_if
    import neuron_dp_pkg::*;
();
    logic [INSTRUCTION_WIDTH-1:0] instruction_dp;
    logic                         start_dp;
    logic [RESULT_WIDTH-1:0]      result_dp;
    logic                         finished_dp;
    logic                         busy;

    modport master (
        output instruction_dp,
        output start_dp,
        input  result_dp,
        input  finished_dp,
        input  busy
    );

    modport slave (
        input  instruction_dp,
        input  start_dp,
        output result_dp,
        output finished_dp,
        output busy
    );
endinterface

// File: rtl/neuron_datapath_seq_mult.sv
`timescale 1ns/1ps
// Signed radix-2 shift-add multiplier, one multiplier bit per cycle.
// Latency MUL_CYCLES cycles after start; no backpressure, a new start restarts it.
module seq_mult #(
    parameter int MUL_CYCLES = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        done,
    output logic [31:0] product
);
    localparam int CW = $clog2(MUL_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    logic [31:0]   mcand_q;
    logic [15:0]   mplier_q;
    logic [31:0]   acc_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    logic          done_q;
    logic [31:0]   addend;

    // The top multiplier bit carries negative weight in two's complement.
    assign addend = (cnt_q == LAST) ? (32'd0 - mcand_q) : mcand_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{16{a[15]}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
            done_q   <= 1'b0;
        end else if (run_q) begin
            if (mplier_q[0])
                acc_q <= acc_q + addend;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign done    = done_q;
    assign product = acc_q;
endmodule

// File: rtl/neuron_datapath.sv
`timescale 1ns/1ps
// Saturating Q8.8 compute engine with persistent accumulator, one instruction at a time.
// Latency 1 edge (MUL/MAC: MUL_CYCLES+1) from capture to finished pulse; start ignored while busy.
module neuron_datapath
    import neuron_dp_pkg::*;
#(
    parameter int MUL_CYCLES = 16
) (
    input  logic              clock,
    input  logic              resetn,
    neuron_datapath_if.slave  dp
);
    state_e                  state_q, state_d;
    instr_t                  instr_q;
    instr_t                  in_instr;
    logic [RESULT_WIDTH-1:0] acc_q, acc_d;
    logic [RESULT_WIDTH-1:0] result_q, result_d;
    logic                    capture;
    logic                    mul_start;
    logic                    mul_done;
    logic [31:0]             mul_product;
    logic signed [31:0]      prod_scaled;
    logic [RESULT_WIDTH-1:0] mul_result;
    logic [RESULT_WIDTH-1:0] mac_result;

    assign in_instr = instr_t'(dp.instruction_dp);

    // Multiplier is launched on the capture edge straight from the bus so the
    // product is ready exactly MUL_CYCLES edges later.
    seq_mult #(.MUL_CYCLES(MUL_CYCLES)) u_mult (
        .clock   (clock),
        .resetn  (resetn),
        .start   (mul_start),
        .a       (in_instr.a),
        .b       (in_instr.b),
        .done    (mul_done),
        .product (mul_product)
    );

    assign prod_scaled = $signed(mul_product) >>> Q_SHIFT;
    assign mul_result  = sat16(prod_scaled);
    assign mac_result  = sat_add(acc_q, mul_result);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        result_d  = result_q;
        capture   = 1'b0;
        mul_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (dp.start_dp) begin
                    capture   = 1'b1;
                    mul_start = is_mul_op(in_instr.opcode);
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                case (instr_q.opcode)
                    OP_NOP:   result_d = '0;
                    OP_ADD:   result_d = sat_add(instr_q.a, instr_q.b);
                    OP_SUB:   result_d = sat_sub(instr_q.a, instr_q.b);
                    OP_MUL: begin
                        if (mul_done)
                            result_d = mul_result;
                        else
                            state_d = ST_EXEC;
                    end
                    OP_MAC: begin
                        if (mul_done) begin
                            acc_d    = mac_result;
                            result_d = mac_result;
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end
                    OP_CLR: begin
                        acc_d    = '0;
                        result_d = '0;
                    end
                    OP_RELU:  result_d = instr_q.a[15] ? '0 : instr_q.a;
                    OP_RDACC: result_d = acc_q;
                    default:  result_d = '0;
                endcase
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            if (capture)
                instr_q <= in_instr;
        end
    end

    assign dp.result_dp   = result_q;
    assign dp.finished_dp = (state_q == ST_DONE);
    assign dp.busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_neuron_datapath.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for neuron_datapath against an integer reference model.
module tb_neuron_datapath;
    localparam int MULC = 16;

    logic clock;
    logic resetn;
    int   total = 0;
    int   bad   = 0;
    int   m_acc = 0;
    logic [15:0] sb[$];

    neuron_datapath_if dp_if();

    neuron_datapath #(.MUL_CYCLES(MULC)) dut (
        .clock  (clock),
        .resetn (resetn),
        .dp     (dp_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sat(input int x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // Reference semantics on plain integers; updates the model accumulator.
    function automatic logic [15:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int ai, bi, r;
        ai = int'($signed(a));
        bi = int'($signed(b));
        case (op)
            4'd1: r = sat(ai + bi);
            4'd2: r = sat(ai - bi);
            4'd3: r = sat((ai * bi) >>> 8);
            4'd4: begin m_acc = sat(m_acc + sat((ai * bi) >>> 8)); r = m_acc; end
            4'd5: begin m_acc = 0; r = 0; end
            4'd6: r = (ai < 0) ? 0 : ai;
            4'd7: r = m_acc;
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    // Monitor: every completion pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (dp_if.finished_dp) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_finish: got result %h with nothing outstanding", dp_if.result_dp);
            end else begin
                chk("result", {16'h0, dp_if.result_dp}, {16'h0, sb.pop_front()});
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input bit hold2, input bit poke);
        logic [15:0] exp;
        int lat, n;
        bit seen;
        exp = model(op, a, b);
        lat = (op == 4'd3 || op == 4'd4) ? MULC + 1 : 1;
        @(negedge clock);
        dp_if.instruction_dp = {op, a, b};
        dp_if.start_dp = 1'b1;
        sb.push_back(exp);
        @(posedge clock);
        #1;
        chk("busy_rise", {31'h0, dp_if.busy}, 32'h1);
        @(negedge clock);
        if (!hold2) dp_if.start_dp = 1'b0;
        dp_if.instruction_dp = {4'($urandom), $urandom};
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(posedge clock);
            n++;
            #1;
            if (n == 1) dp_if.start_dp = 1'b0;
            if (poke && n == 5) begin
                dp_if.start_dp = 1'b1;
                dp_if.instruction_dp = {4'd1, $urandom};
            end
            if (poke && n == 6) dp_if.start_dp = 1'b0;
            if (dp_if.finished_dp) seen = 1'b1;
            else if (n < lat) chk("busy_hold", {31'h0, dp_if.busy}, 32'h1);
        end
        chk("latency", seen ? n : -1, lat);
        @(posedge clock);
        #1;
        chk("finish_fall", {31'h0, dp_if.finished_dp}, 32'h0);
        chk("busy_fall", {31'h0, dp_if.busy}, 32'h0);
        chk("result_hold", {16'h0, dp_if.result_dp}, {16'h0, exp});
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 3))
            0: return 16'($urandom);
            1: return 16'h7FFF - 16'($urandom_range(0, 255));
            2: return 16'h8000 + 16'($urandom_range(0, 255));
            default: return 16'($urandom_range(0, 1023));
        endcase
    endfunction

    initial begin
        resetn = 1'b0;
        dp_if.start_dp = 1'b0;
        dp_if.instruction_dp = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_result", {16'h0, dp_if.result_dp}, 32'h0);
        chk("rst_finished", {31'h0, dp_if.finished_dp}, 32'h0);
        chk("rst_busy", {31'h0, dp_if.busy}, 32'h0);
        @(negedge clock);
        resetn = 1'b1;

        issue(4'd1, 16'h0100, 16'h0280, 0, 0);
        issue(4'd3, 16'h0180, 16'hFE00, 0, 0);
        issue(4'd1, 16'h7F00, 16'h0200, 0, 0);
        issue(4'd2, 16'h8100, 16'h0200, 0, 0);
        issue(4'd3, 16'h4000, 16'h0400, 0, 0);
        issue(4'd5, 16'h0000, 16'h0000, 0, 0);
        issue(4'd4, 16'h0200, 16'h0300, 0, 0);
        issue(4'd4, 16'h0100, 16'h0080, 0, 0);
        issue(4'd7, 16'h0000, 16'h0000, 0, 0);
        issue(4'd6, 16'hFF00, 16'h0000, 1, 0);
        issue(4'd3, 16'h0300, 16'h0240, 0, 1);
        issue(4'd9, 16'h1234, 16'h5678, 0, 0);
        repeat (3) @(posedge clock);

        for (int i = 0; i < 60; i++) begin
            issue(4'($urandom_range(0, 15)), rnd16(), rnd16(), $urandom_range(0, 3) == 0, 0);
            repeat ($urandom_range(0, 2)) @(posedge clock);
        end

        // Abort a MAC with reset; accumulator must come back as zero.
        issue(4'd4, 16'h0100, 16'h0100, 0, 0);
        @(negedge clock);
        dp_if.instruction_dp = {4'd4, 16'h0200, 16'h0300};
        dp_if.start_dp = 1'b1;
        @(posedge clock);
        @(negedge clock);
        dp_if.start_dp = 1'b0;
        resetn = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        chk("abort_result", {16'h0, dp_if.result_dp}, 32'h0);
        chk("abort_finished", {31'h0, dp_if.finished_dp}, 32'h0);
        chk("abort_busy", {31'h0, dp_if.busy}, 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        m_acc = 0;
        repeat (MULC + 4) @(posedge clock);
        issue(4'd7, 16'h0000, 16'h0000, 0, 0);

        repeat (5) @(posedge clock);
        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
